rr_grant_arbiter: RTL and testbench

RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

---
 rtl/rr_grant_arbiter_if.sv | 23 ++
 rtl/rr_grant_arbiter.sv | 103 ++++++++++
 tb/tb_rr_grant_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_grant_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_arbiter_if
// Brief    : Request/grant bundle between four requesters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_grant_arbiter_if;
  logic       ra, rb, rc, rd;
  logic       ga, gb, gc, gd;
  logic       busy;
  logic [1:0] owner;

  modport master (
    output ra, rb, rc, rd,
    input  ga, gb, gc, gd, busy, owner
  );

  modport slave (
    input  ra, rb, rc, rd,
    output ga, gb, gc, gd, busy, owner
  );
endinterface
`default_nettype wire

// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_arbiter
// Brief    : Four-way round-robin arbiter with registered one-hot grants.
//            Macro ARB_TIMEOUT_EN adds a tenure counter that preempts a holder
//            after TENURE cycles when another requester is waiting.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter #(
  parameter int TENURE = 8
) (
  input  logic                clk,
  input  logic                reset,
  rr_grant_arbiter_if.slave   bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0] r_state;
  logic [3:0] r_grant;
  logic [1:0] r_owner;

  logic [3:0] w_req;
  logic [3:0] w_mask;
  logic       w_holder_req;
  logic       w_sat;
  logic       w_arb;
  logic       w_found;
  logic [1:0] w_sel;
  logic       w_load;

  if (TENURE < 2 || TENURE > 255) begin : g_tenure_range
    $error("rr_grant_arbiter: TENURE must lie in 2..255");
  end

  assign w_req        = {bus.rd, bus.rc, bus.rb, bus.ra};
  assign w_holder_req = |(w_req & r_grant);
  // The current holder never competes in a handover or preemption search.
  assign w_mask       = (r_state == S_IDLE) ? w_req : (w_req & ~r_grant);
  assign w_arb        = (r_state == S_IDLE) || !w_holder_req || (w_sat && w_found);
  assign w_load       = w_arb && w_found;

  always_comb begin
    logic [1:0] w_idx;
    w_found = 1'b0;
    w_sel   = r_owner;
    w_idx   = r_owner;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_owner + 2'(k);
      if (!w_found && w_mask[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] c_TENURE_LAST = 8'(TENURE - 1);

  logic [7:0] r_cnt;

  assign w_sat = (r_cnt == c_TENURE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 8'd0;
    end else if (w_load) begin
      r_cnt <= 8'd0;
    end else if (r_state == S_GRANT && !w_sat) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
`else
  assign w_sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= 4'b0000;
      r_owner <= 2'd3;
    end else if (w_arb) begin
      if (w_found) begin
        r_state <= S_GRANT;
        r_grant <= 4'b0001 << w_sel;
        r_owner <= w_sel;
      end else begin
        r_state <= S_IDLE;
        r_grant <= 4'b0000;
      end
    end
  end

  assign bus.ga    = r_grant[0];
  assign bus.gb    = r_grant[1];
  assign bus.gc    = r_grant[2];
  assign bus.gd    = r_grant[3];
  assign bus.busy  = |r_grant;
  assign bus.owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_grant_arbiter
// Brief    : Self-checking bench: directed scenarios plus random traffic
//            compared against an integer-level round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter;
  localparam int TENURE = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  int m_holder = -1;
  int m_owner  = 3;
  int m_cnt    = 0;

  rr_grant_arbiter_if bus ();

  rr_grant_arbiter #(.TENURE(TENURE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] w_g;
  assign w_g = {bus.gd, bus.gc, bus.gb, bus.ga};

  function automatic int rr_pick(input logic [3:0] req, input int after, input int skip);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (after + k) % 4;
      if (req[i] && i != skip) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_grants();
    return (m_holder < 0) ? 4'b0000 : 4'(1 << m_holder);
  endfunction

  task automatic model_edge();
    logic [3:0] req;
    logic [3:0] others;
    bit         expired;
    int         p;
    req = {bus.rd, bus.rc, bus.rb, bus.ra};
    if (reset) begin
      m_holder = -1;
      m_owner  = 3;
      m_cnt    = 0;
    end else if (m_holder < 0) begin
      p = rr_pick(req, m_owner, -1);
      if (p >= 0) begin
        m_holder = p;
        m_owner  = p;
        m_cnt    = 0;
      end
    end else begin
      others = req & ~4'(1 << m_holder);
`ifdef ARB_TIMEOUT_EN
      expired = (m_cnt == TENURE - 1) && (others != 4'b0000);
`else
      expired = 1'b0;
`endif
      if (!req[m_holder] || expired) begin
        p = rr_pick(req, m_owner, m_holder);
        if (p >= 0) begin
          m_holder = p;
          m_owner  = p;
          m_cnt    = 0;
        end else begin
          m_holder = -1;
        end
      end else if (m_cnt < TENURE - 1) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    {bus.rd, bus.rc, bus.rb, bus.ra} = r;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    set_req(4'b0000);
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(4'b0000);
    step();
    step();
    n_checks++;
    if (w_g !== 4'b0000) begin n_errors++; $display("FAIL reset_grants got %b want 0000", w_g); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++;
    if (bus.owner !== 2'd3) begin n_errors++; $display("FAIL reset_owner got %0d want 3", bus.owner); end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1;
    set_req(4'b1111);
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if (w_g !== 4'b0001) begin n_errors++; $display("FAIL prio_grant got %b want 0001", w_g); end
    n_checks++;
    if (bus.owner !== 2'd0) begin n_errors++; $display("FAIL prio_owner got %0d want 0", bus.owner); end
  endtask

  task automatic test_round_robin();
    set_req(4'b1110);
    step();
    n_checks++;
    if (w_g !== 4'b0010) begin n_errors++; $display("FAIL rr_b got %b want 0010", w_g); end
    set_req(4'b1101);
    step();
    n_checks++;
    if (w_g !== 4'b0100) begin n_errors++; $display("FAIL rr_c got %b want 0100", w_g); end
    set_req(4'b1001);
    step();
    n_checks++;
    if (w_g !== 4'b1000) begin n_errors++; $display("FAIL rr_d got %b want 1000", w_g); end
    set_req(4'b0001);
    step();
    n_checks++;
    if (w_g !== 4'b0001 || bus.owner !== 2'd0) begin
      n_errors++; $display("FAIL rr_a got %b/%0d want 0001/0", w_g, bus.owner);
    end
    set_req(4'b0000);
    step();
    n_checks++;
    if (w_g !== 4'b0000 || bus.busy !== 1'b0 || bus.owner !== 2'd0) begin
      n_errors++; $display("FAIL rr_idle got %b/%b/%0d want 0000/0/0", w_g, bus.busy, bus.owner);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    pulse_reset();
    set_req(4'b0011);
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (w_g !== 4'b0001) begin n_errors++; $display("FAIL timeout_hold[%0d] got %b want 0001", i, w_g); end
    end
    step();
    n_checks++;
    if (w_g !== 4'b0010) begin n_errors++; $display("FAIL timeout_move got %b want 0010", w_g); end
    set_req(4'b0000);
    step();
  endtask

  task automatic test_lone_holder();
    pulse_reset();
    set_req(4'b0100);
    for (int i = 1; i <= 19; i++) begin
      step();
      n_checks++;
      if (w_g !== 4'b0100) begin n_errors++; $display("FAIL lone_hold[%0d] got %b want 0100", i, w_g); end
    end
    set_req(4'b1100);
    step();
    n_checks++;
    if (w_g !== 4'b1000 || bus.owner !== 2'd3) begin
      n_errors++; $display("FAIL lone_preempt got %b/%0d want 1000/3", w_g, bus.owner);
    end
    set_req(4'b0000);
    step();
  endtask
`else
  task automatic test_no_timeout();
    pulse_reset();
    set_req(4'b0011);
    for (int i = 1; i <= 30; i++) begin
      step();
      n_checks++;
      if (w_g !== 4'b0001) begin n_errors++; $display("FAIL notimeout_hold[%0d] got %b want 0001", i, w_g); end
    end
    set_req(4'b0010);
    step();
    n_checks++;
    if (w_g !== 4'b0010) begin n_errors++; $display("FAIL notimeout_handover got %b want 0010", w_g); end
    set_req(4'b0000);
    step();
  endtask
`endif

  task automatic test_mid_reset();
    pulse_reset();
    set_req(4'b0010);
    step();
    n_checks++;
    if (w_g !== 4'b0010) begin n_errors++; $display("FAIL midrst_pre got %b want 0010", w_g); end
    reset = 1'b1;
    step();
    n_checks++;
    if (w_g !== 4'b0000 || bus.owner !== 2'd3 || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL midrst_clear got %b/%0d/%b want 0000/3/0", w_g, bus.owner, bus.busy);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (w_g !== 4'b0010 || bus.owner !== 2'd1) begin
      n_errors++; $display("FAIL midrst_regrant got %b/%0d want 0010/1", w_g, bus.owner);
    end
    set_req(4'b0000);
    step();
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] exp_g;
    r = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      set_req(r);
      reset = ($urandom_range(0, 63) == 0);
      step();
      exp_g = model_grants();
      n_checks++;
      if (w_g !== exp_g) begin n_errors++; $display("FAIL rand_grants cyc %0d got %b want %b", c, w_g, exp_g); end
      n_checks++;
      if (bus.owner !== 2'(m_owner)) begin n_errors++; $display("FAIL rand_owner cyc %0d got %0d want %0d", c, bus.owner, m_owner); end
      n_checks++;
      if (bus.busy !== (m_holder >= 0)) begin n_errors++; $display("FAIL rand_busy cyc %0d got %b want %b", c, bus.busy, m_holder >= 0); end
      n_checks++;
      if ($countones(w_g) > 1) begin n_errors++; $display("FAIL rand_onehot cyc %0d got %b want at most one bit", c, w_g); end
    end
    reset = 1'b0;
  endtask

  initial begin
    set_req(4'b0000);
    test_reset();
    test_reset_priority();
    test_round_robin();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
    test_lone_holder();
`else
    test_no_timeout();
`endif
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
